// File: rtl/fm_mod_pkg.sv
// Package functs: shared Q10 fixed-point helpers and constants for the FM
// modulator slice (phase/angle constants, CORDIC gain and arctangent table).
package functs;

  localparam int PI_Q10      = 3217;
  localparam int HALF_PI_Q10 = 1608;
  localparam int TWO_PI_Q10  = 2 * PI_Q10;
  localparam int CORDIC_K    = 622;

  // atan(2^-i) in Q10 radians, i = 0..9
  localparam logic signed [31:0] ATAN_Q10 [0:9] = '{
    32'sd804, 32'sd475, 32'sd251, 32'sd127, 32'sd64,
    32'sd32,  32'sd16,  32'sd8,   32'sd4,   32'sd2
  };

  // Q10 multiply: full 64-bit product, arithmetic shift by 10, keep low 32 bits
  function automatic logic signed [31:0] mul_frac10_32b(input logic signed [31:0] a,
                                                        input logic signed [31:0] b);
    logic signed [63:0] ae;
    logic signed [63:0] be;
    logic signed [63:0] p;
    ae = 64'(a);
    be = 64'(b);
    p  = ae * be;
    return p[41:10];
  endfunction

  // Q10 to integer (floor)
  function automatic logic signed [31:0] DEQUANTIZE(input logic signed [31:0] v);
    return v >>> 10;
  endfunction

endpackage

// File: rtl/fm_mod_cordic.sv
// cordic_sincos: iterative rotation-mode CORDIC, one iteration per clock.
// Angles outside +-pi/2 are folded by pi and the result negated.
module cordic_sincos
  import functs::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned ITER       = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] angle,
  input  logic signed [DATA_WIDTH-1:0] x0,
  output logic signed [DATA_WIDTH-1:0] cos_out,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic                         done
);

  localparam logic [3:0] LAST = 4'(ITER - 1);

  logic signed [DATA_WIDTH-1:0] x, y, z;
  logic signed [DATA_WIDTH-1:0] x_nx, y_nx, z_nx;
  logic signed [DATA_WIDTH-1:0] z_init;
  logic                         neg_init;
  logic                         neg;
  logic                         busy;
  logic [3:0]                   iter_cnt;

  // Fold the start angle into +-pi/2 and remember whether to negate
  always_comb begin
    z_init   = angle;
    neg_init = 1'b0;
    if (angle > HALF_PI_Q10) begin
      z_init   = angle - PI_Q10;
      neg_init = 1'b1;
    end else if (angle < -HALF_PI_Q10) begin
      z_init   = angle + PI_Q10;
      neg_init = 1'b1;
    end
  end

  // One micro-rotation, direction taken from the sign of the residual angle
  always_comb begin
    if (!z[DATA_WIDTH-1]) begin
      x_nx = x - (y >>> iter_cnt);
      y_nx = y + (x >>> iter_cnt);
      z_nx = z - ATAN_Q10[iter_cnt];
    end else begin
      x_nx = x + (y >>> iter_cnt);
      y_nx = y - (x >>> iter_cnt);
      z_nx = z + ATAN_Q10[iter_cnt];
    end
  end

  // Iteration state; start is ignored while busy, done is a one-cycle pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      neg      <= 1'b0;
      busy     <= 1'b0;
      iter_cnt <= '0;
      cos_out  <= '0;
      sin_out  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        x <= x_nx;
        y <= y_nx;
        z <= z_nx;
        if (iter_cnt == LAST) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          cos_out <= neg ? -x_nx : x_nx;
          sin_out <= neg ? -y_nx : y_nx;
        end else begin
          iter_cnt <= iter_cnt + 4'd1;
        end
      end else if (start) begin
        x        <= x0;
        y        <= '0;
        z        <= z_init;
        neg      <= neg_init;
        iter_cnt <= '0;
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fm_mod.sv
// fm_mod: baseband FM modulator. Pops an audio sample, accumulates it into a
// wrapped Q10 phase and pushes the CORDIC cos/sin pair to the I and Q FIFOs.
// Optional pre-emphasis is enabled by defining FM_MOD_PREEMPH_EN.
module fm_mod
  import functs::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEVIATION   = 1383,
  parameter int          AMPL        = 1024,
  parameter int unsigned CORDIC_ITER = 10,
  parameter int          PREEMPH_K   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] audio,
  output logic                         rd_en_audio,
  input  logic                         empty_audio,
  output logic signed [DATA_WIDTH-1:0] rl_out,
  output logic                         wr_en_rl,
  input  logic                         full_rl,
  output logic signed [DATA_WIDTH-1:0] img_out,
  output logic                         wr_en_img,
  input  logic                         full_img
);

  typedef enum logic [1:0] {S_READ, S_PHASE, S_CORDIC, S_WRITE} state_t;

  localparam logic signed [DATA_WIDTH-1:0] X0 = mul_frac10_32b(AMPL, CORDIC_K);

  state_t state, state_nx;

  logic signed [DATA_WIDTH-1:0] phase;
  logic signed [DATA_WIDTH-1:0] sample;
  logic signed [DATA_WIDTH-1:0] s_eff;
  logic signed [DATA_WIDTH-1:0] phase_sum;
  logic signed [DATA_WIDTH-1:0] phase_c;
  logic signed [DATA_WIDTH-1:0] cos_r, sin_r;
  logic signed [DATA_WIDTH-1:0] cordic_cos, cordic_sin;
  logic                         cordic_done;
  logic                         cordic_start;
  logic                         push;

`ifdef FM_MOD_PREEMPH_EN
  logic signed [DATA_WIDTH-1:0] x_prev;
`endif

  // Next phase: accumulate the scaled sample, wrap once into [-pi, pi)
  always_comb begin
    s_eff = sample;
`ifdef FM_MOD_PREEMPH_EN
    s_eff = sample + mul_frac10_32b(PREEMPH_K, sample - x_prev);
`endif
    phase_sum = phase + mul_frac10_32b(DEVIATION, s_eff);
    phase_c   = phase_sum;
    if (phase_sum >= PI_Q10) begin
      phase_c = phase_sum - TWO_PI_Q10;
    end else if (phase_sum < -PI_Q10) begin
      phase_c = phase_sum + TWO_PI_Q10;
    end
  end

  // Next-state and FIFO handshakes; both FIFOs are pushed together or not at all
  always_comb begin
    state_nx     = state;
    rd_en_audio  = 1'b0;
    cordic_start = 1'b0;
    push         = 1'b0;
    case (state)
      S_READ: begin
        if (!empty_audio && !rst) begin
          rd_en_audio = 1'b1;
          state_nx    = S_PHASE;
        end
      end
      S_PHASE: begin
        cordic_start = 1'b1;
        state_nx     = S_CORDIC;
      end
      S_CORDIC: begin
        if (cordic_done) begin
          state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!full_rl && !full_img) begin
          push     = 1'b1;
          state_nx = S_READ;
        end
      end
      default: state_nx = S_READ;
    endcase
  end

  // Outputs read zero unless a pair is being pushed
  always_comb begin
    wr_en_rl  = push;
    wr_en_img = push;
    rl_out    = push ? cos_r : '0;
    img_out   = push ? sin_r : '0;
  end

  // State, sample capture, phase update and result latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_READ;
      phase  <= '0;
      sample <= '0;
      cos_r  <= '0;
      sin_r  <= '0;
    end else begin
      state <= state_nx;
      if (rd_en_audio) begin
        sample <= audio;
      end
      if (state == S_PHASE) begin
        phase <= phase_c;
      end
      if ((state == S_CORDIC) && cordic_done) begin
        cos_r <= cordic_cos;
        sin_r <= cordic_sin;
      end
    end
  end

`ifdef FM_MOD_PREEMPH_EN
  // Previous accepted sample for the pre-emphasis difference
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_prev <= '0;
    end else if (state == S_PHASE) begin
      x_prev <= sample;
    end
  end
`endif

  cordic_sincos #(
    .DATA_WIDTH(DATA_WIDTH),
    .ITER      (CORDIC_ITER)
  ) u_cordic (
    .clk    (clk),
    .rst    (rst),
    .start  (cordic_start),
    .angle  (phase_c),
    .x0     (X0),
    .cos_out(cordic_cos),
    .sin_out(cordic_sin),
    .done   (cordic_done)
  );

endmodule

// File: tb/tb_fm_mod.sv
// Self-checking bench for fm_mod: FIFO-side stimulus with a real-valued
// phase/sin/cos reference model.
module tb_fm_mod;

  localparam int DEV   = 1383;
  localparam int AMP   = 1024;
  localparam int ITERS = 10;
  localparam int PIQ   = 3217;
  localparam int TOL   = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] audio;
  logic               rd_en_audio;
  logic               empty_audio;
  logic signed [31:0] rl_out;
  logic               wr_en_rl;
  logic               full_rl;
  logic signed [31:0] img_out;
  logic               wr_en_img;
  logic               full_img;

  fm_mod #(
    .DATA_WIDTH (32),
    .DEVIATION  (DEV),
    .AMPL       (AMP),
    .CORDIC_ITER(ITERS),
    .PREEMPH_K  (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .audio      (audio),
    .rd_en_audio(rd_en_audio),
    .empty_audio(empty_audio),
    .rl_out     (rl_out),
    .wr_en_rl   (wr_en_rl),
    .full_rl    (full_rl),
    .img_out    (img_out),
    .wr_en_img  (wr_en_img),
    .full_img   (full_img)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   src[$];
  int   exp_ph[$];
  int   push_cyc[$];
  bit   force_empty = 1'b0;
  int   m_phase = 0;
  int   m_xprev = 0;
  int   pops = 0;
  int   pushes = 0;
  int   cyc = 0;
  logic last_rd, last_wr_rl, last_wr_img;

  function automatic int mulq(input int a, input int b);
    longint p;
    p = (longint'(a) * longint'(b)) >>> 10;
    return int'(p);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic signed [31:0] obs, input int lo, input int hi);
    checks++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=[%0d,%0d]", tag, obs, lo, hi);
    end
  endtask

  // Reference: accepted sample -> new wrapped phase
  task automatic model_accept(input int smp);
    int s;
    s = smp;
`ifdef FM_MOD_PREEMPH_EN
    s = smp + mulq(1024, smp - m_xprev);
    m_xprev = smp;
`endif
    m_phase = m_phase + mulq(DEV, s);
    if (m_phase >= PIQ) m_phase -= 2 * PIQ;
    else if (m_phase < -PIQ) m_phase += 2 * PIQ;
    exp_ph.push_back(m_phase);
  endtask

  task automatic check_pair(input int ph);
    real er, ei;
    int  ir, ii;
    er = AMP * $cos(ph / 1024.0);
    ei = AMP * $sin(ph / 1024.0);
    ir = $rtoi(er);
    ii = $rtoi(ei);
    if (ph == 0) begin
      chk_rng("rl_zero_phase", rl_out, 1020, 1027);
      chk_rng("img_zero_phase", img_out, -4, 4);
    end else begin
      chk_rng("rl_vs_model", rl_out, ir - TOL, ir + TOL);
      chk_rng("img_vs_model", img_out, ii - TOL, ii + TOL);
    end
  endtask

  task automatic drive();
    empty_audio = force_empty || (src.size() == 0);
    audio = (src.size() > 0) ? src[0] : int'($urandom);
  endtask

  // One clock: observe at the falling edge, update FIFO-side inputs after the rising edge
  task automatic cycle();
    bit popped;
    int ph;
    popped = 1'b0;
    @(negedge clk);
    cyc++;
    last_rd     = rd_en_audio;
    last_wr_rl  = wr_en_rl;
    last_wr_img = wr_en_img;
    if (rd_en_audio === 1'b1) begin
      chk("pop_only_when_ready", {31'd0, empty_audio}, 0);
      chk("one_sample_in_flight", pops - pushes, 0);
      model_accept(audio);
      pops++;
      popped = 1'b1;
    end
    if ((wr_en_rl === 1'b1) || (wr_en_img === 1'b1)) begin
      chk("push_rl_en", {31'd0, wr_en_rl}, 1);
      chk("push_img_en", {31'd0, wr_en_img}, 1);
      chk("push_not_full", {30'd0, full_rl, full_img}, 0);
      if (exp_ph.size() == 0) begin
        chk("push_has_sample", exp_ph.size(), 1);
      end else begin
        ph = exp_ph.pop_front();
        check_pair(ph);
      end
      pushes++;
      push_cyc.push_back(cyc);
    end else if ((cyc % 8) == 0) begin
      chk("rl_idle_zero", rl_out, 0);
      chk("img_idle_zero", img_out, 0);
    end
    @(posedge clk);
    #1;
    if (popped && (src.size() > 0)) void'(src.pop_front());
    drive();
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while (((src.size() > 0) || (pushes != pops)) && (n < budget)) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, src.size() + (pops - pushes), 0);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_xprev = 0;
    exp_ph.delete();
    pushes = pops;
  endtask

  initial begin
    int p0, q0, rng, n;
    rst = 1'b1;
    full_rl = 1'b0;
    full_img = 1'b0;
    drive();
    repeat (3) cycle();
    chk("rst_rd_en", {31'd0, last_rd}, 0);
    chk("rst_wr_en_rl", {31'd0, last_wr_rl}, 0);
    chk("rst_wr_en_img", {31'd0, last_wr_img}, 0);
    chk("rst_rl_out", rl_out, 0);
    chk("rst_img_out", img_out, 0);
    rst = 1'b0;
    repeat (2) cycle();

    // Silent audio keeps the phase at zero
    repeat (6) src.push_back(0);
    drive();
    drain(200, "zero");
    chk("zero_pair_count", pushes, 6);

`ifndef FM_MOD_PREEMPH_EN
    // Phase wrap and fold boundaries, starting from phase 0
    src = '{2382, 2382, -1000, -1381, 2382, 1191, 1, -1191};
    drive();
    drain(300, "bounds");
`endif

    // pi/4 steps, back-to-back with no stalls
    push_cyc.delete();
    repeat (8) src.push_back(596);
    drive();
    drain(300, "quarter");
    chk("quarter_pair_count", push_cyc.size(), 8);
    for (int i = 1; i < push_cyc.size(); i++) begin
      chk("pair_interval", push_cyc[i] - push_cyc[i-1], ITERS + 4);
    end

    // Random audio within the contract range
`ifdef FM_MOD_PREEMPH_EN
    rng = 700;
`else
    rng = 2000;
`endif
    for (int i = 0; i < 40; i++) src.push_back(int'($urandom_range(2 * rng)) - rng);
    drive();
    drain(1000, "random");

    // Back-pressure: Q FIFO full, then I FIFO full, then release
    p0 = pushes;
    q0 = pops;
    src.push_back(300);
    src.push_back(-450);
    full_img = 1'b1;
    drive();
    repeat (20) cycle();
    chk("stall_img_no_push", pushes - p0, 0);
    chk("stall_img_one_pop", pops - q0, 1);
    full_img = 1'b0;
    full_rl = 1'b1;
    repeat (5) cycle();
    chk("stall_rl_no_push", pushes - p0, 0);
    full_rl = 1'b0;
    repeat (3) cycle();
    chk("release_one_push", pushes - p0, 1);
    drain(100, "stall");

    // Audio FIFO toggling empty every cycle
    p0 = pushes;
    q0 = pops;
    for (int i = 0; i < 10; i++) src.push_back(int'($urandom_range(1200)) - 600);
    n = 0;
    while (((src.size() > 0) || (pushes != pops)) && (n < 800)) begin
      force_empty = ~force_empty;
      drive();
      cycle();
      n++;
    end
    force_empty = 1'b0;
    drive();
    chk("toggle_pops", pops - q0, 10);
    chk("toggle_pushes", pushes - p0, 10);

    // Reset while the CORDIC is running
    src.push_back(1000);
    drive();
    n = 0;
    do begin
      cycle();
      n++;
    end while ((last_rd !== 1'b1) && (n < 20));
    chk("rst_test_pop_seen", {31'd0, last_rd}, 1);
    repeat (4) cycle();
    rst = 1'b1;
    model_reset();
    cycle();
    chk("midrst_rd_en", {31'd0, last_rd}, 0);
    chk("midrst_wr_en_rl", {31'd0, last_wr_rl}, 0);
    chk("midrst_wr_en_img", {31'd0, last_wr_img}, 0);
    cycle();
    rst = 1'b0;
    p0 = pushes;
    src.push_back(0);
    src.push_back(0);
    drive();
    drain(200, "after_rst");
    chk("after_rst_pairs", pushes - p0, 2);

`ifdef FM_MOD_PREEMPH_EN
    // Pre-emphasis step from rest: first effective sample doubles
    src.push_back(512);
    drive();
    drain(100, "preemph_step");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
